// File: rtl/heartbeat_generator_if.sv
// Signal bundle between the control loop / watchdog side and the heartbeat
// generator. Inputs are sampled on the rising clock edge. Outputs are
// registered, so a consumer may sample them on any later edge.
interface heartbeat_generator_if;
  logic       enable;       // level: kicking permitted while high
  logic       alive;        // single-cycle liveness strobe from the control loop
  logic       force_reset;  // level from the watchdog, overrides everything
  logic       heartbeat;    // keep-alive pulse to the watchdog
  logic       kicking;      // generator is in RUN
  logic       starved;      // generator is in STARVED
  logic [3:0] miss_cnt;     // consecutive alive-less periods, saturating

  // Control loop / watchdog side.
  modport master (
    output enable, alive, force_reset,
    input  heartbeat, kicking, starved, miss_cnt
  );

  // Heartbeat generator side.
  modport slave (
    input  enable, alive, force_reset,
    output heartbeat, kicking, starved, miss_cnt
  );
endinterface

// File: rtl/heartbeat_generator.sv
// Heartbeat generator: converts control-loop liveness strobes into periodic
// keep-alive pulses for the watchdog. It stops kicking after MISS_LIMIT silent
// periods. After a watchdog force_reset it waits HOLDOFF quiet cycles before
// kicking again.
module heartbeat_generator #(
  parameter int PERIOD     = 1000,
  parameter int PULSE_W    = 1,
  parameter int HOLDOFF    = 16,
  parameter int MISS_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  heartbeat_generator_if.slave  bus,
  output logic [1:0]            state_dbg
);

  localparam int PW  = (PERIOD  > 1) ? $clog2(PERIOD)      : 1;
  localparam int HW  = $clog2(HOLDOFF + 1);
  localparam int PCW = $clog2(PULSE_W + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STARVED = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   period_q, period_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [PCW-1:0]  pcnt_q, pcnt_d;
  logic [3:0]      miss_q, miss_d;
  logic            seen_q, seen_d;
  logic            hb_q, hb_d;
  logic            kick_q, starved_q;
  logic [3:0]      miss_inc;
  logic            boundary;

  assign boundary = (period_q == PW'(PERIOD - 1));
  assign miss_inc = (miss_q == 4'd15) ? 4'd15 : (miss_q + 4'd1);

  // State, counters and registered outputs. rst clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      period_q  <= '0;
      hold_q    <= '0;
      pcnt_q    <= '0;
      miss_q    <= '0;
      seen_q    <= 1'b0;
      hb_q      <= 1'b0;
      kick_q    <= 1'b0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      hold_q    <= hold_d;
      pcnt_q    <= pcnt_d;
      miss_q    <= miss_d;
      seen_q    <= seen_d;
      hb_q      <= hb_d;
      kick_q    <= (state_d == S_RUN);
      starved_q <= (state_d == S_STARVED);
    end
  end

  // Next state, counters and pulse. Priority: force_reset, then enable low, then the state rules.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    hold_d   = hold_q;
    pcnt_d   = pcnt_q;
    miss_d   = miss_q;
    seen_d   = seen_q;
    hb_d     = 1'b0;

    // An active pulse keeps running until its width is used up.
    if (hb_q && (pcnt_q != '0)) begin
      hb_d   = 1'b1;
      pcnt_d = pcnt_q - PCW'(1);
    end

    if (bus.force_reset) begin
      state_d  = S_HOLDOFF;
      hold_d   = '0;
      period_d = '0;
      seen_d   = 1'b0;
      miss_d   = '0;
      pcnt_d   = '0;
      hb_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.enable) begin
            state_d  = S_RUN;
            period_d = '0;
          end
        end
        S_HOLDOFF: begin
          // enable is looked at only when the quiet window has fully elapsed.
          if (hold_q == HW'(HOLDOFF - 1)) begin
            state_d  = bus.enable ? S_RUN : S_IDLE;
            hold_d   = '0;
            period_d = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        default: begin  // S_RUN, S_STARVED
          if (!bus.enable) begin
            state_d  = S_IDLE;
            period_d = '0;
            hold_d   = '0;
            seen_d   = 1'b0;
            miss_d   = '0;
            pcnt_d   = '0;
            hb_d     = 1'b0;
          end else if ((state_q == S_STARVED) && bus.alive) begin
            // Recovery: the strobe that wakes us counts for the new period.
            state_d  = S_RUN;
            period_d = '0;
            miss_d   = '0;
            seen_d   = 1'b1;
          end else if (boundary) begin
            period_d = '0;
            seen_d   = 1'b0;
            if ((state_q == S_RUN) && (seen_q || bus.alive)) begin
              hb_d   = 1'b1;
              pcnt_d = PCW'(PULSE_W - 1);
              miss_d = '0;
            end else begin
              miss_d = miss_inc;
              if ((state_q == S_RUN) && (miss_inc >= 4'(MISS_LIMIT)))
                state_d = S_STARVED;
            end
          end else begin
            period_d = period_q + PW'(1);
            seen_d   = seen_q | bus.alive;
          end
        end
      endcase
    end
  end

  assign bus.heartbeat = hb_q;
  assign bus.kicking   = kick_q;
  assign bus.starved   = starved_q;
  assign bus.miss_cnt  = miss_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_heartbeat_generator.sv
// Bench for heartbeat_generator. Directed scenarios are pinned with literal
// cycle expectations. A behavioural model of the heartbeat rules tracks the
// expected outputs, and the DUT is compared against it every cycle. The run
// ends with a long randomized phase.
module tb_heartbeat_generator;
  localparam int PERIOD     = 8;
  localparam int PULSE_W    = 2;
  localparam int HOLDOFF    = 4;
  localparam int MISS_LIMIT = 3;

  localparam int M_IDLE = 0, M_RUN = 1, M_STARVED = 2, M_HOLD = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state_dbg;

  heartbeat_generator_if bus();

  heartbeat_generator #(
    .PERIOD(PERIOD), .PULSE_W(PULSE_W), .HOLDOFF(HOLDOFF), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // behavioural model: mode, position in period, liveness, misses, remaining pulse cycles
  int m_mode, m_phase, m_miss, m_pulse_left, m_quiet;
  bit m_seen;

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_miss = 0; m_pulse_left = 0; m_quiet = 0; m_seen = 0;
  endtask

  task automatic model_step(input bit e, input bit a, input bit f);
    if (f) begin
      m_mode = M_HOLD; m_quiet = 0; m_phase = 0; m_seen = 0; m_miss = 0; m_pulse_left = 0;
    end else if (m_mode == M_HOLD) begin
      m_quiet++;
      if (m_quiet == HOLDOFF) begin
        m_mode = e ? M_RUN : M_IDLE;
        m_phase = 0; m_quiet = 0;
      end
    end else if (!e) begin
      m_mode = M_IDLE; m_phase = 0; m_seen = 0; m_miss = 0; m_pulse_left = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RUN; m_phase = 0;
    end else begin
      if (m_pulse_left > 0) m_pulse_left--;
      if (m_mode == M_STARVED && a) begin
        m_mode = M_RUN; m_phase = 0; m_miss = 0; m_seen = 1;
      end else if (m_phase == PERIOD - 1) begin
        if (m_mode == M_RUN && (m_seen || a)) begin
          m_pulse_left = PULSE_W;
          m_miss = 0;
        end else begin
          m_miss = (m_miss + 1 > 15) ? 15 : m_miss + 1;
          if (m_mode == M_RUN && m_miss >= MISS_LIMIT) m_mode = M_STARVED;
        end
        m_phase = 0; m_seen = 0;
      end else begin
        m_phase++;
        m_seen = m_seen | a;
      end
    end
  endtask

  // Compare the current cycle against the model, apply the inputs, advance one clock.
  task automatic cycle(input bit e, input bit a, input bit f);
    chk("heartbeat", int'(bus.heartbeat), (m_pulse_left > 0) ? 1 : 0);
    chk("kicking",   int'(bus.kicking),   (m_mode == M_RUN) ? 1 : 0);
    chk("starved",   int'(bus.starved),   (m_mode == M_STARVED) ? 1 : 0);
    chk("miss_cnt",  int'(bus.miss_cnt),  m_miss);
    bus.enable = e; bus.alive = a; bus.force_reset = f;
    @(posedge clk);
    model_step(e, a, f);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.enable = 1'b0; bus.alive = 1'b0; bus.force_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  int density;

  initial begin
    bus.enable = 1'b0; bus.alive = 1'b0; bus.force_reset = 1'b0;
    model_reset();

    // reset state
    do_reset();
    chk("rst_heartbeat", int'(bus.heartbeat), 0);
    chk("rst_kicking",   int'(bus.kicking),   0);
    chk("rst_starved",   int'(bus.starved),   0);
    chk("rst_miss",      int'(bus.miss_cnt),  0);

    // steady kicking: alive every 3 cycles
    do_reset();
    while (cyc < 30) begin
      if (cyc == 1)  chk("steady_kick1", int'(bus.kicking), 1);
      if (cyc == 8 || cyc == 11 || cyc == 16 || cyc == 19)
        chk("steady_hb_low", int'(bus.heartbeat), 0);
      if (cyc == 9 || cyc == 10 || cyc == 17 || cyc == 18 || cyc == 25 || cyc == 26)
        chk("steady_hb_high", int'(bus.heartbeat), 1);
      if (cyc == 27) chk("steady_miss", int'(bus.miss_cnt), 0);
      cycle(1'b1, (cyc % 3) == 0, 1'b0);
    end

    // starvation: no alive for a long run
    do_reset();
    while (cyc < 140) begin
      if (cyc == 8)  chk("starve_miss8",  int'(bus.miss_cnt), 0);
      if (cyc == 9)  chk("starve_miss9",  int'(bus.miss_cnt), 1);
      if (cyc == 17) chk("starve_miss17", int'(bus.miss_cnt), 2);
      if (cyc == 25) chk("starve_miss25", int'(bus.miss_cnt), 3);
      if (cyc == 24) chk("starve_flag24", int'(bus.starved),  0);
      if (cyc == 25) chk("starve_flag25", int'(bus.starved),  1);
      if (cyc == 30) chk("starve_nokick", int'(bus.kicking),  0);
      cycle(1'b1, 1'b0, 1'b0);
    end
    chk("starve_saturate", int'(bus.miss_cnt), 15);

    // recovery from STARVED: one strobe at cycle 30, then steady alive
    do_reset();
    while (cyc < 45) begin
      if (cyc == 31) chk("recover_kick31", int'(bus.kicking),  1);
      if (cyc == 31) chk("recover_miss31", int'(bus.miss_cnt), 0);
      if (cyc == 38) chk("recover_hb38",   int'(bus.heartbeat), 0);
      if (cyc == 39 || cyc == 40) chk("recover_hb", int'(bus.heartbeat), 1);
      cycle(1'b1, cyc == 30, 1'b0);
    end

    // alive only on boundary cycles
    do_reset();
    while (cyc < 30) begin
      if (cyc == 9 || cyc == 17 || cyc == 25) chk("bnd_hb", int'(bus.heartbeat), 1);
      if (cyc == 26) chk("bnd_miss", int'(bus.miss_cnt), 0);
      cycle(1'b1, (cyc > 0) && (cyc % PERIOD == 0), 1'b0);
    end

    // force_reset mid-pulse
    do_reset();
    while (cyc < 26) begin
      if (cyc == 9)  chk("fr_hb9",    int'(bus.heartbeat), 1);
      if (cyc == 10) chk("fr_hb10",   int'(bus.heartbeat), 0);
      if (cyc == 10 || cyc == 13) chk("fr_hold_nokick", int'(bus.kicking), 0);
      if (cyc == 14) chk("fr_kick14", int'(bus.kicking),   1);
      if (cyc == 21) chk("fr_hb21",   int'(bus.heartbeat), 0);
      if (cyc == 22 || cyc == 23) chk("fr_hb_again", int'(bus.heartbeat), 1);
      cycle(1'b1, (cyc % 3) == 0, cyc == 9);
    end

    // enable drop and re-enable
    do_reset();
    while (cyc < 33) begin
      if (cyc == 6)  chk("en_kick6",  int'(bus.kicking),   0);
      if (cyc == 28) chk("en_hb28",   int'(bus.heartbeat), 0);
      if (cyc == 29 || cyc == 30) chk("en_hb", int'(bus.heartbeat), 1);
      cycle(!(cyc >= 5 && cyc < 20), 1'b1, 1'b0);
    end

    // asynchronous reset in the middle of a pulse
    do_reset();
    while (cyc < 9) cycle(1'b1, 1'b1, 1'b0);
    chk("arst_hb_before", int'(bus.heartbeat), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hb_drop",   int'(bus.heartbeat), 0);
    chk("arst_kick_drop", int'(bus.kicking),   0);
    bus.enable = 1'b0; bus.alive = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc = 0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);

    // randomized run against the model
    do_reset();
    density = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) density = $urandom_range(0, 6);
      cycle($urandom_range(0, 99) < 96,
            $urandom_range(0, 19) < density,
            $urandom_range(0, 249) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/heartbeat_generator.md
# heartbeat_generator

Keep-alive source for the `watchdog_timer`: it turns liveness strobes from the control loop into periodic `heartbeat` pulses. If the control loop goes silent for `MISS_LIMIT` consecutive periods, it deliberately stops kicking, so the watchdog expires. It sits between the control loop and the watchdog, and obeys the watchdog's `force_reset` by entering a recovery holdoff before kicking again.

## Interface
- `PERIOD`, 1000: cycles per heartbeat period; legal range ≥ 4.
- `PULSE_W`, 1: heartbeat pulse width in cycles; legal range 1 ≤ `PULSE_W` < `PERIOD`.
- `HOLDOFF`, 16: quiet cycles required after `force_reset` deasserts before resuming; legal range ≥ 1.
- `MISS_LIMIT`, 3: consecutive alive-less periods before entering STARVED; legal range 1..15.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level; allows kicking when high.
- `alive` in 1: single-cycle liveness strobe from the control loop; any number of strobes per period is allowed.
- `force_reset` in 1: level from the watchdog; highest priority.
- `heartbeat` out 1: registered keep-alive pulse to the watchdog.
- `kicking` out 1: high in RUN.
- `starved` out 1: high in STARVED.
- `miss_cnt` out 4: consecutive missed periods, saturating at 15.

## Operation
- **States:** IDLE, RUN, STARVED, HOLDOFF. Encoding is free.
- **Per-cycle priority:**
  1. `force_reset`
  2. `enable` low
  3. state logic
- **Any state, `force_reset`=1:**
  - Go to HOLDOFF and clear the holdoff counter.
  - Clear the period counter, `alive_seen`, `miss_cnt` and the pulse counter.
- **HOLDOFF:**
  - Counts cycles with `force_reset`=0; any `force_reset`=1 restarts the count.
  - After `HOLDOFF` consecutive quiet cycles, go to RUN if `enable`=1, else IDLE.
- **RUN/STARVED with `enable`=0:** go to IDLE and clear all counters and `alive_seen`.
- **IDLE with `enable`=1:** go to RUN with period counter 0.
- **Period counter (RUN and STARVED):**
  - Counts 0..`PERIOD`-1 and wraps to 0.
  - The cycle with count = `PERIOD`-1 is the boundary.
- **`alive_seen` latch:**
  - Set by `alive` in RUN or STARVED.
  - Cleared at every boundary.
  - An `alive` on the boundary cycle counts for the period that is ending (use `alive_seen | alive`).
- **RUN boundary with liveness:** start a heartbeat pulse and clear `miss_cnt`.
- **RUN boundary without liveness:**
  - No pulse; `miss_cnt` increments (saturating at 15).
  - If the new value ≥ `MISS_LIMIT`, go to STARVED.
- **STARVED:**
  - Never pulses; boundaries still increment `miss_cnt` (saturating).
  - An `alive` strobe moves the block to RUN on the next cycle: period counter 0, `miss_cnt` 0, `alive_seen` 1.
- **Pulse:**
  - Once started, `heartbeat` stays high for exactly `PULSE_W` cycles.
  - The pulse is truncated immediately by `force_reset`, by `enable` low, or by `rst`.

## Timing
- **Reset values:** `heartbeat`=0, `kicking`=0, `starved`=0, `miss_cnt`=0, state IDLE, all counters 0.
- **Reset timing:** outputs clear asynchronously on `rst` assertion; `rst` release is synchronous to `clk`.
- **All outputs are registered.**
- **`heartbeat` timing:** rises on the clock edge ending the boundary cycle, i.e. with 1 cycle of latency from the boundary.
- **Truncation latency:** `force_reset`=1 or `enable`=0 in cycle N gives `heartbeat`=0 and `kicking`=0 in cycle N+1.
- **First pulse:** with `enable` first sampled high in cycle 0, RUN begins with count 0 in cycle 1. The first boundary is cycle `PERIOD`, so `heartbeat` is high in cycles `PERIOD`+1 .. `PERIOD`+`PULSE_W`.
- **Steady-state spacing:** heartbeat rising edges are exactly `PERIOD` cycles apart.
- **`miss_cnt`/`starved` update:** the cycle after the boundary.
- **HOLDOFF exit:** with `force_reset` last high in cycle N, the state is RUN in cycle N+`HOLDOFF`+1.

## Test plan
All scenarios use `PERIOD`=8, `PULSE_W`=2, `HOLDOFF`=4, `MISS_LIMIT`=3.
- **Steady kicking:** reset, then `enable`=1 from cycle 0 and `alive` every 3 cycles -> `heartbeat` high in cycles 9–10, 17–18, 25–26; `miss_cnt`=0; `kicking`=1 from cycle 1.
- **Starvation:** `enable`=1, `alive`=0 throughout -> `miss_cnt` reads 1, 2, 3 after cycles 8, 16, 24; `starved`=1 from cycle 25; `heartbeat` never rises; `miss_cnt` saturates at 15 by a long run.
- **Recovery from STARVED:** `alive` single strobe at cycle 30 -> RUN in cycle 31 with count 0; `heartbeat` high in cycles 39–40; `miss_cnt`=0.
- **Boundary alive:** `alive` only on each boundary cycle (8, 16, …) -> a pulse every period and `miss_cnt` stays 0.
- **Force reset mid-pulse:** `force_reset`=1 in cycle 9 only -> `heartbeat`=0 in cycle 10; HOLDOFF in cycles 10–13; RUN in cycle 14; next `heartbeat` in cycles 22–23 (given `alive`).
- **Enable drop and async reset:**
  - `enable`=0 at cycle 5 -> IDLE with all outputs 0 from cycle 6; re-enabling at cycle 20 -> pulse in cycles 29–30.
  - `rst` pulsed mid-pulse, between clock edges -> `heartbeat` drops without waiting for a clock edge.
